prog_reflector: RTL and testbench

Programmable Enigma reflector (UKW-D style) that replaces the fixed-wiring reflector in the rotor datapath. It holds an active pairing table used for 1-cycle registered lookups, and a shadow table that a host loads pair-by-pair over a valid/ready handshake. After validation, the shadow table is committed atomically to the active table. Reset loads standard UKW-B wiring, so the machine works with no configuration.

---
 rtl/enigma_pkg.sv | 33 +++
 rtl/refl_shadow_table.sv | 54 +++++
 rtl/prog_reflector.sv | 174 +++++++++++++++++
 tb/tb_prog_reflector.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared constants for the programmable reflector: default sizes, the UKW-B wiring,
// error codes and the configuration FSM state encoding.
package enigma_pkg;

  localparam int unsigned AlphaDefault = 26;
  localparam int unsigned WidthDefault = 5;

  // UKW-B: AY BR CU DH EQ FS GL IP JX KN MO TZ VW
  localparam int unsigned UkwB [26] = '{
    24, 17, 20,  7, 16, 18, 11,  3, 15, 23, 13,  6, 14,
    10, 12,  8,  4,  1,  5, 25,  2, 22, 21,  9,  0, 19
  };

  localparam logic [1:0] ErrNone     = 2'd0;
  localparam logic [1:0] ErrRange    = 2'd1;
  localparam logic [1:0] ErrSelf     = 2'd2;
  localparam logic [1:0] ErrConflict = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StProg,
    StCommit
  } refl_state_e;

  // Reset wiring: UKW-B for the real alphabet, adjacent swaps for any other even size.
  function automatic int unsigned ukw_default(int unsigned alpha, int unsigned idx);
    if (alpha == 26) begin
      return UkwB[idx[4:0]];
    end
    return idx ^ 32'd1;
  endfunction

endpackage

// File: rtl/refl_shadow_table.sv
// Shadow pairing table: letter map plus assigned bitmap, written one pair at a time.
module refl_shadow_table
  import enigma_pkg::*;
#(
  parameter int unsigned ALPHA = AlphaDefault,
  parameter int unsigned W     = WidthDefault
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         wr_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         conflict_o,
  output logic [W-1:0] map_o [ALPHA]
);

  logic [ALPHA-1:0] assigned_q;
  logic [W-1:0]     map_q [ALPHA];

  // Out-of-range letters never match an index, so they never flag a conflict.
  always_comb begin
    conflict_o = 1'b0;
    for (int unsigned i = 0; i < ALPHA; i++) begin
      if ((a_i == W'(i) || b_i == W'(i)) && assigned_q[i]) begin
        conflict_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      assigned_q <= '0;
      for (int unsigned i = 0; i < ALPHA; i++) begin
        map_q[i] <= '0;
      end
    end else if (clr_i) begin
      assigned_q <= '0;
    end else if (wr_i) begin
      for (int unsigned i = 0; i < ALPHA; i++) begin
        if (a_i == W'(i)) begin
          map_q[i]      <= b_i;
          assigned_q[i] <= 1'b1;
        end else if (b_i == W'(i)) begin
          map_q[i]      <= a_i;
          assigned_q[i] <= 1'b1;
        end
      end
    end
  end

  assign map_o = map_q;

endmodule

// File: rtl/prog_reflector.sv
// Programmable Enigma reflector: registered lookup through the active table, with a
// host-loaded shadow table committed atomically after the session holds a full pairing.
module prog_reflector
  import enigma_pkg::*;
#(
  parameter int unsigned ALPHA = AlphaDefault,
  parameter int unsigned W     = WidthDefault
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_start,
  input  logic         cfg_abort,
  input  logic         cfg_commit,
  input  logic         cfg_pair_valid,
  output logic         cfg_pair_ready,
  input  logic [W-1:0] cfg_a,
  input  logic [W-1:0] cfg_b,
  output logic         cfg_busy,
  output logic         cfg_done,
  output logic         cfg_err,
  output logic [1:0]   cfg_err_code,
  input  logic         lk_valid,
  input  logic [W-1:0] lk_in,
  output logic         lk_out_valid,
  output logic [W-1:0] lk_out,
  output logic         lk_range_err
);

  localparam int unsigned CntW   = $clog2(ALPHA / 2 + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(ALPHA / 2);
  localparam logic [W:0] AlphaW  = (W + 1)'(ALPHA);

  refl_state_e     state_q;
  logic [CntW-1:0] pair_cnt_q;
  logic            done_q, err_q;
  logic [1:0]      err_code_q;
  logic [W-1:0]    active_q [ALPHA];
  logic [W-1:0]    shadow_map [ALPHA];
  logic            shadow_conflict, shadow_clr, shadow_wr;
  logic            in_prog, take_abort, take_commit, take_pair, take_restart;
  logic [1:0]      pair_code;
  logic            lk_out_valid_q, lk_range_err_q;
  logic [W-1:0]    lk_out_q, lk_map;
  logic            lk_oor;

  always_comb begin
    if (({1'b0, cfg_a} >= AlphaW) || ({1'b0, cfg_b} >= AlphaW)) begin
      pair_code = ErrRange;
    end else if (cfg_a == cfg_b) begin
      pair_code = ErrSelf;
    end else if (shadow_conflict) begin
      pair_code = ErrConflict;
    end else begin
      pair_code = ErrNone;
    end
  end

  // Priority inside a session: abort, commit, pair write, restart.
  assign in_prog      = (state_q == StProg);
  assign take_abort   = in_prog && cfg_abort;
  assign take_commit  = in_prog && !cfg_abort && cfg_commit;
  assign take_pair    = in_prog && !cfg_abort && !cfg_commit && cfg_pair_valid;
  assign take_restart = in_prog && !cfg_abort && !cfg_commit && !cfg_pair_valid && cfg_start;
  assign shadow_clr   = ((state_q == StIdle) && cfg_start) || take_restart || take_abort;
  assign shadow_wr    = take_pair && (pair_code == ErrNone);

  refl_shadow_table #(
    .ALPHA (ALPHA),
    .W     (W)
  ) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (shadow_clr),
    .wr_i       (shadow_wr),
    .a_i        (cfg_a),
    .b_i        (cfg_b),
    .conflict_o (shadow_conflict),
    .map_o      (shadow_map)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pair_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
      unique case (state_q)
        StIdle: begin
          if (cfg_start) begin
            state_q    <= StProg;
            pair_cnt_q <= '0;
          end
        end
        StProg: begin
          if (take_abort) begin
            state_q <= StIdle;
          end else if (take_commit) begin
            if (pair_cnt_q == FullCnt) begin
              state_q <= StCommit;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ErrConflict;
            end
          end else if (take_pair) begin
            if (pair_code != ErrNone) begin
              err_q      <= 1'b1;
              err_code_q <= pair_code;
            end else begin
              pair_cnt_q <= pair_cnt_q + 1'b1;
            end
          end else if (take_restart) begin
            pair_cnt_q <= '0;
          end
        end
        StCommit: begin
          state_q <= StIdle;
          done_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ALPHA; i++) begin
        active_q[i] <= W'(ukw_default(ALPHA, i));
      end
    end else if (state_q == StCommit) begin
      active_q <= shadow_map;
    end
  end

  // Out-of-range letters fall through the mux unchanged.
  always_comb begin
    lk_map = lk_in;
    for (int unsigned i = 0; i < ALPHA; i++) begin
      if (lk_in == W'(i)) begin
        lk_map = active_q[i];
      end
    end
  end

  assign lk_oor = ({1'b0, lk_in} >= AlphaW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_out_valid_q <= 1'b0;
      lk_out_q       <= '0;
      lk_range_err_q <= 1'b0;
    end else begin
      lk_out_valid_q <= lk_valid;
      if (lk_valid) begin
        lk_out_q       <= lk_map;
        lk_range_err_q <= lk_oor;
      end
    end
  end

  assign cfg_busy       = in_prog;
  assign cfg_pair_ready = in_prog;
  assign cfg_done       = done_q;
  assign cfg_err        = err_q;
  assign cfg_err_code   = err_code_q;
  assign lk_out_valid   = lk_out_valid_q;
  assign lk_out         = lk_out_q;
  assign lk_range_err   = lk_range_err_q;

endmodule

// File: tb/tb_prog_reflector.sv
// Self-checking bench for prog_reflector against a letter-pairing reference model.
module tb_prog_reflector;

  localparam int ALPHA = 26;
  localparam int W     = 5;
  localparam int HALF  = ALPHA / 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_start, cfg_abort, cfg_commit, cfg_pair_valid;
  logic         cfg_pair_ready, cfg_busy, cfg_done, cfg_err;
  logic [W-1:0] cfg_a, cfg_b;
  logic [1:0]   cfg_err_code;
  logic         lk_valid, lk_out_valid, lk_range_err;
  logic [W-1:0] lk_in, lk_out;

  always #5 clk = ~clk;

  prog_reflector #(
    .ALPHA (ALPHA),
    .W     (W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .cfg_abort      (cfg_abort),
    .cfg_commit     (cfg_commit),
    .cfg_pair_valid (cfg_pair_valid),
    .cfg_pair_ready (cfg_pair_ready),
    .cfg_a          (cfg_a),
    .cfg_b          (cfg_b),
    .cfg_busy       (cfg_busy),
    .cfg_done       (cfg_done),
    .cfg_err        (cfg_err),
    .cfg_err_code   (cfg_err_code),
    .lk_valid       (lk_valid),
    .lk_in          (lk_in),
    .lk_out_valid   (lk_out_valid),
    .lk_out         (lk_out),
    .lk_range_err   (lk_range_err)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    ref_active [ALPHA];
  int    ref_shadow [ALPHA];  // -1 = unassigned
  int    ref_cnt;
  string ukwb = "AYBRCUDHEQFSGLIPJXKNMOTZVW";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < HALF; k++) begin
      int a = int'(ukwb[2*k]) - int'("A");
      int b = int'(ukwb[2*k+1]) - int'("A");
      ref_active[a] = b;
      ref_active[b] = a;
    end
    for (int i = 0; i < ALPHA; i++) ref_shadow[i] = -1;
    ref_cnt = 0;
  endtask

  function automatic int ref_map(input int x);
    return (x < ALPHA) ? ref_active[x] : x;
  endfunction

  task automatic do_lookup(input string tag, input int x);
    lk_valid = 1'b1;
    lk_in    = W'(x);
    tick();
    lk_valid = 1'b0;
    chk({tag, ".vld"}, 32'(lk_out_valid), 1);
    chk({tag, ".out"}, 32'(lk_out), ref_map(x));
    chk({tag, ".rng"}, 32'(lk_range_err), (x >= ALPHA) ? 1 : 0);
  endtask

  task automatic do_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < ALPHA; i++) ref_shadow[i] = -1;
    ref_cnt = 0;
    chk("start.busy", 32'(cfg_busy), 1);
    chk("start.ready", 32'(cfg_pair_ready), 1);
  endtask

  task automatic do_pair(input string tag, input int a, input int b);
    int code;
    if (a >= ALPHA || b >= ALPHA)                  code = 1;
    else if (a == b)                               code = 2;
    else if (ref_shadow[a] >= 0 || ref_shadow[b] >= 0) code = 3;
    else begin
      code = 0;
      ref_shadow[a] = b;
      ref_shadow[b] = a;
      ref_cnt++;
    end
    cfg_pair_valid = 1'b1;
    cfg_a = W'(a);
    cfg_b = W'(b);
    tick();
    cfg_pair_valid = 1'b0;
    chk({tag, ".err"}, 32'(cfg_err), (code != 0) ? 1 : 0);
    chk({tag, ".code"}, 32'(cfg_err_code), code);
  endtask

  task automatic do_commit(input string tag);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    if (ref_cnt == HALF) begin
      chk({tag, ".leave"}, 32'(cfg_busy), 0);
      chk({tag, ".noerr"}, 32'(cfg_err), 0);
      tick();
      chk({tag, ".done"}, 32'(cfg_done), 1);
      for (int i = 0; i < ALPHA; i++) ref_active[i] = ref_shadow[i];
    end else begin
      chk({tag, ".err"}, 32'(cfg_err), 1);
      chk({tag, ".code"}, 32'(cfg_err_code), 3);
      chk({tag, ".busy"}, 32'(cfg_busy), 1);
    end
  endtask

  initial begin
    int perm [ALPHA];
    int old_a, old_z;
    rst = 1'b1;
    cfg_start = 1'b0; cfg_abort = 1'b0; cfg_commit = 1'b0; cfg_pair_valid = 1'b0;
    cfg_a = '0; cfg_b = '0; lk_valid = 1'b0; lk_in = '0;
    model_reset();
    #12;
    chk("rst.busy", 32'(cfg_busy), 0);
    chk("rst.ready", 32'(cfg_pair_ready), 0);
    chk("rst.done", 32'(cfg_done), 0);
    chk("rst.err", 32'(cfg_err), 0);
    chk("rst.vld", 32'(lk_out_valid), 0);
    chk("rst.out", 32'(lk_out), 0);
    rst = 1'b0;

    do_lookup("lkA", 0);
    chk("lkA.const", 32'(lk_out), 24);
    do_lookup("lkE", 4);
    chk("lkE.const", 32'(lk_out), 16);
    do_lookup("lkZ", 25);
    chk("lkZ.const", 32'(lk_out), 19);
    do_lookup("lk30", 30);
    tick();
    chk("hold.vld", 32'(lk_out_valid), 0);
    chk("hold.out", 32'(lk_out), 30);

    // Commit and pairs in IDLE are ignored
    cfg_commit = 1'b1; cfg_pair_valid = 1'b1; cfg_a = 5'd0; cfg_b = 5'd1;
    tick();
    cfg_commit = 1'b0; cfg_pair_valid = 1'b0;
    chk("idle.busy", 32'(cfg_busy), 0);
    chk("idle.err", 32'(cfg_err), 0);
    chk("idle.done", 32'(cfg_done), 0);

    do_start();
    do_lookup("progA", 0);
    do_pair("self", 3, 3);
    do_pair("range", 0, 27);
    do_pair("AB", 0, 1);
    do_pair("AC", 0, 2);
    for (int k = 1; k < HALF - 1; k++) do_pair("seq", 2*k, 2*k+1);
    do_commit("short");
    do_pair("YZ", 24, 25);

    // Back-to-back lookups across the commit
    old_a = ref_active[0];
    old_z = ref_active[25];
    cfg_commit = 1'b1; lk_valid = 1'b1; lk_in = 5'd0;
    tick();
    cfg_commit = 1'b0; lk_in = 5'd25;
    chk("b2b.pre", 32'(lk_out), old_a);
    chk("b2b.leave", 32'(cfg_busy), 0);
    tick();
    chk("b2b.commitcyc", 32'(lk_out), old_z);
    chk("b2b.done", 32'(cfg_done), 1);
    for (int i = 0; i < ALPHA; i++) ref_active[i] = ref_shadow[i];
    lk_in = 5'd0;
    tick();
    lk_valid = 1'b0;
    chk("b2b.new", 32'(lk_out), ref_active[0]);
    chk("b2b.newconst", 32'(lk_out), 1);
    do_lookup("newZ", 25);
    chk("newZ.const", 32'(lk_out), 24);

    // Abort keeps the custom active table
    do_start();
    do_pair("abpair", 0, 5);
    cfg_abort = 1'b1; cfg_commit = 1'b1;
    tick();
    cfg_abort = 1'b0; cfg_commit = 1'b0;
    chk("abort.busy", 32'(cfg_busy), 0);
    chk("abort.done", 32'(cfg_done), 0);
    do_lookup("abortA", 0);

    // Random sessions with junk pairs mixed in
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < ALPHA; i++) perm[i] = i;
      for (int i = ALPHA - 1; i > 0; i--) begin
        int j = int'($urandom_range(0, i));
        int t = perm[i];
        perm[i] = perm[j];
        perm[j] = t;
      end
      do_start();
      for (int k = 0; k < HALF; k++) begin
        if ($urandom_range(0, 3) == 0) do_pair("junk", int'($urandom_range(0, 31)),
                                                       int'($urandom_range(0, 31)));
        do_pair("rnd", perm[2*k], perm[2*k+1]);
      end
      if (ref_cnt != HALF) begin
        do_commit("rshort");
        for (int i = 0; i < ALPHA; i++) begin
          if (ref_shadow[i] < 0) begin
            for (int j = i + 1; j < ALPHA; j++) begin
              if (ref_shadow[j] < 0 && ref_shadow[i] < 0) do_pair("fill", i, j);
            end
          end
        end
      end
      do_commit("rcommit");
      for (int n = 0; n < 12; n++) do_lookup("rlk", int'($urandom_range(0, 31)));
    end

    // Reset mid-session after 5 pairs
    do_start();
    for (int k = 0; k < 5; k++) do_pair("pre", 2*k, 2*k+1);
    rst = 1'b1;
    #2;
    chk("mrst.busy", 32'(cfg_busy), 0);
    chk("mrst.ready", 32'(cfg_pair_ready), 0);
    rst = 1'b0;
    model_reset();
    do_lookup("mrstA", 0);
    chk("mrstA.const", 32'(lk_out), 24);
    do_lookup("mrstE", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
